// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, one bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-2:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic               bit_s;
    logic               bit_c;
    logic               last_bit;
    logic [WIDTH-1:0]   acc_full;

    // Full-adder cell on the current operand LSBs
    assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_c    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));
    // Working sum after this bit: new bit enters from the MSB side
    assign acc_full = {bit_s, acc_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_full[WIDTH-1:1];
                carry_d = bit_c;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    sum_d   = acc_full;
                    cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus a random stream
// scored against plain integer addition.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int          NPAIRS = 1000;
    localparam int          LIMIT  = NPAIRS * 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int passes = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: unsigned (WIDTH+1)-bit sum and signed overflow from integer arithmetic
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned t;
        t = int'(x) + int'(y);
        return t[WIDTH:0];
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int sx;
        int sy;
        sx = (x >= 8'h80) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'h80) ? int'(y) - 256 : int'(y);
        return ((sx + sy) > 127) || ((sx + sy) < -128);
    endfunction

    // Presents one pair in IDLE; returns one time unit after the accepting edge
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(posedge clk) #1;
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_result();
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, out_valid, busy, carry_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset: rdy/vld/busy/cout/sum got %b%b%b%b %h want 1000 00",
                     in_ready, out_valid, busy, carry_out, sum);
        else passes++;
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
        else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int n;
        start_op(8'h00, 8'h00);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100)
            $display("FAIL zero_run_flags: busy/rdy/vld got %b%b%b want 100", busy, in_ready, out_valid);
        else passes++;
        wait_done(n);
        checks++;
        if (n !== WIDTH + 1) $display("FAIL zero_latency: got %0d negedges want %0d", n, WIDTH + 1);
        else passes++;
        checks++;
        if ({carry_out, sum} !== ref_sum(8'h00, 8'h00))
            $display("FAIL zero_sum: got %b %h want 0 00", carry_out, sum);
        else passes++;
        release_result();
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL zero_handshake: vld/rdy got %b%b want 01", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_carry_wrap();
        int n;
        start_op(8'hFF, 8'h01);
        wait_done(n);
        checks++;
        if ({carry_out, sum} !== 9'h100)
            $display("FAIL ff01_sum: got %b %h want 1 00", carry_out, sum);
        else passes++;
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) $display("FAIL ff01_ovf: got %b want 0", ovf);
        else passes++;
`endif
        release_result();
    endtask

    task automatic test_signed_ovf();
        int n;
        start_op(8'h7F, 8'h01);
        wait_done(n);
        checks++;
        if ({carry_out, sum} !== 9'h080)
            $display("FAIL 7f01_sum: got %b %h want 0 80", carry_out, sum);
        else passes++;
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b1) $display("FAIL 7f01_ovf: got %b want 1", ovf);
        else passes++;
`endif
        release_result();
    endtask

    task automatic test_stall();
        int n;
        start_op(8'h3C, 8'hA5);
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        checks++;
        if ({busy, in_ready, sum} !== {1'b1, 1'b0, 8'h80})
            $display("FAIL stall_run_prev: busy/rdy/sum got %b%b %h want 10 80", busy, in_ready, sum);
        else passes++;
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, carry_out, sum} !== {1'b1, 1'b0, 1'b0, 8'hE1})
                $display("FAIL stall_hold%0d: vld/rdy/cout/sum got %b%b%b %h want 100 e1",
                         i, out_valid, in_ready, carry_out, sum);
            else passes++;
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, sum} !== {1'b1, 8'hE1})
            $display("FAIL stall_idle: rdy/sum got %b %h want 1 e1", in_ready, sum);
        else passes++;
        @(posedge clk) #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL stall_second_accept: busy got %b want 1", busy);
        else passes++;
        wait_done(n);
        checks++;
        if ({carry_out, sum} !== ref_sum(8'h11, 8'h22))
            $display("FAIL stall_second_sum: got %b %h want 0 33", carry_out, sum);
        else passes++;
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_op(8'hAA, 8'h55);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001)
            $display("FAIL abort: vld/busy/rdy got %b%b%b want 001", out_valid, busy, in_ready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h01, 8'h02);
        wait_done(n);
        checks++;
        if (n !== WIDTH + 1) $display("FAIL abort_latency: got %0d want %0d", n, WIDTH + 1);
        else passes++;
        checks++;
        if ({carry_out, sum} !== 9'h003)
            $display("FAIL abort_sum: got %b %h want 0 03", carry_out, sum);
        else passes++;
        release_result();
    endtask

    task automatic test_throughput();
        int acc_t[$];
        @(posedge clk) #1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 8'h12;
        b = 8'h34;
        for (int i = 0; i < 3 * (WIDTH + 2) + 2; i++) begin
            @(negedge clk);
            if (in_ready) acc_t.push_back(i);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        repeat (2 * WIDTH + 4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (acc_t.size() < 2) $display("FAIL throughput: got %0d acceptances want >=2", acc_t.size());
        else if (acc_t[1] - acc_t[0] !== WIDTH + 2)
            $display("FAIL throughput: got period %0d want %0d", acc_t[1] - acc_t[0], WIDTH + 2);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH+1:0] q[$];
        int sent = 0;
        int rcvd = 0;
        fork
            begin
                int guard = 0;
                while (sent < NPAIRS && guard < LIMIT) begin
                    @(posedge clk) #1;
                    if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
                    else begin
                        in_valid = 1'b1;
                        a = WIDTH'($urandom);
                        b = WIDTH'($urandom);
                    end
                    @(negedge clk);
                    guard++;
                    if (in_valid && in_ready) begin
                        q.push_back({ref_ovf(a, b), ref_sum(a, b)});
                        sent++;
                    end
                end
                @(posedge clk) #1;
                in_valid = 1'b0;
            end
            begin
                int guard = 0;
                logic [WIDTH+1:0] exp;
                while (rcvd < NPAIRS && guard < LIMIT) begin
                    @(posedge clk) #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    guard++;
                    if (out_valid && out_ready) begin
                        rcvd++;
                        checks++;
                        if (q.size() == 0) $display("FAIL stream_extra: result %0d with empty queue", rcvd);
                        else begin
                            exp = q.pop_front();
                            if ({carry_out, sum} !== exp[WIDTH:0])
                                $display("FAIL stream_sum%0d: got %h want %h", rcvd,
                                         {carry_out, sum}, exp[WIDTH:0]);
`ifdef SERIAL_ADDER_OVF_EN
                            else if (ovf !== exp[WIDTH+1])
                                $display("FAIL stream_ovf%0d: got %b want %b", rcvd, ovf, exp[WIDTH+1]);
`endif
                            else passes++;
                        end
                    end
                end
                @(posedge clk) #1;
                out_ready = 1'b0;
            end
        join
        checks++;
        if (sent !== NPAIRS || rcvd !== NPAIRS || q.size() !== 0)
            $display("FAIL stream_count: sent %0d rcvd %0d left %0d want %0d/%0d/0",
                     sent, rcvd, q.size(), NPAIRS, NPAIRS);
        else passes++;
        repeat (2 * WIDTH) @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stream_drain: vld/rdy got %b%b want 01", out_valid, in_ready);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_wrap();
        test_signed_ovf();
        test_stall();
        test_reset_mid_run();
        test_throughput();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A, unsigned (two's complement when OVF feature is enabled).
REQ-007 b  input  WIDTH  operand B.
REQ-008 out_valid  output  1  sum/carry_out hold a completed result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-011 carry_out  output  1  carry out of bit WIDTH-1.
REQ-012 busy  output  1  high in RUN state.
REQ-013 ovf  output  1  signed overflow; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-014 The block SHALL implement a bit-serial adder: one half-adder pair plus a carry flip-flop (full-adder cell) and shift registers, one bit per clock, LSB first.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL capture a and b into shift registers, clear the carry flip-flop, clear the bit counter and go to RUN.
REQ-017 RUN: each cycle the block SHALL compute bit s=a0^b0^c, c'=(a0&b0)|(c&(a0^b0)), shift s into the sum register from the MSB side, shift both operand registers right by one and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 SHALL transition to DONE.
REQ-019 Latency: if acceptance occurs at edge T, out_valid SHALL first be high after edge T+WIDTH.
REQ-020 DONE: out_valid=1; sum and carry_out SHALL remain stable until out_valid&&out_ready, after which the state returns to IDLE on that edge.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid and changes on a/b in those states SHALL be ignored.
REQ-022 out_ready SHALL be ignored outside DONE; out_ready held high gives a throughput of one result per WIDTH+2 cycles.
REQ-023 sum and carry_out SHALL show the last completed result while in IDLE and RUN. They are qualified only by out_valid.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during RUN.

Reset
REQ-025 When rst_n is low, the block SHALL go to IDLE immediately, regardless of clk.
REQ-026 Reset values: in_ready=1 (after reset, in IDLE), out_valid=0, busy=0, sum=0, carry_out=0, ovf=0, carry flip-flop=0, counter=0.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no output handshake; the first acceptance after rst_n rises SHALL behave exactly as from power-up.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN. When defined, port ovf SHALL exist. It is registered at the last RUN edge as (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the operand MSBs captured at acceptance. It SHALL be valid and held with out_valid.
REQ-029 When SERIAL_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-030 Apply a=0x00, b=0x00 in IDLE -> out_valid high 8 cycles after acceptance, sum=0x00, carry_out=0.
REQ-031 Apply a=0xFF, b=0x01 -> sum=0x00, carry_out=1; with the OVF feature enabled, ovf=0.
REQ-032 Apply a=0x7F, b=0x01 with SERIAL_ADDER_OVF_EN defined -> sum=0x80, carry_out=0, ovf=1.
REQ-033 Apply a=0x3C, b=0xA5, hold out_ready=0 for 5 cycles in DONE, and drive in_valid high with a=0x11 throughout -> sum=0xE1, carry_out=0 held stable, in_ready=0, second operand not accepted until after the out handshake.
REQ-034 Accept a=0xAA, b=0x55, assert rst_n=0 after 3 RUN cycles -> out_valid=0, busy=0 and in_ready=1 at once. Then accept a=0x01, b=0x02 -> sum=0x03, carry_out=0 with no residual carry.
REQ-035 Random back-to-back stream of 1000 pairs with random out_ready -> every result equals a+b (9-bit compare), no pair dropped or duplicated.
